// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and constants for the memory access sequencer.
//   state_e : sequencer FSM states (IDLE / ACCESS / DONE)
//   op_e    : latched operation kind (OP_RD / OP_WR)
//   AW_DEF, DW_DEF, WAIT_DEF : default address/data widths and wait states
//   MAX_WAIT, CNT_W          : wait counter range and width
package mem_seq_pkg;

  localparam int AW_DEF   = 16;
  localparam int DW_DEF   = 16;
  localparam int WAIT_DEF = 2;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: bus bundle between the requester (AR / data bus / RAM side)
// and the sequencer.
//   Requester -> sequencer : addr_in, wdata, rd_req, wr_req, inc, mem_rdata
//   Sequencer -> requester : mem_addr, mem_wdata, mem_oe, mem_we, rdata,
//                            busy, done, ar_inc, err
// Modports: master = requester/RAM side, slave = mem_seq.
interface mem_seq_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata;
  logic          rd_req;
  logic          wr_req;
  logic          inc;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_oe;
  logic          mem_we;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          ar_inc;
  logic          err;

  modport master (
    output addr_in, wdata, rd_req, wr_req, inc, mem_rdata,
    input  mem_addr, mem_wdata, mem_oe, mem_we, rdata, busy, done, ar_inc, err
  );

  modport slave (
    input  addr_in, wdata, rd_req, wr_req, inc, mem_rdata,
    output mem_addr, mem_wdata, mem_oe, mem_we, rdata, busy, done, ar_inc, err
  );

endinterface

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable 4-bit down-counter timing the ACCESS phase.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val (takes priority over en)
//   en        : decrement by one
//   load_val  : value to load
//   zero      : count is zero
module mem_wait_cnt
  import mem_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Wait-state count register: load on request, count down during ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_seq.sv
// mem_seq: single-cycle-issue memory access sequencer behind the AR.
// Takes one read or write request in IDLE, drives the RAM for WAIT+1 cycles,
// then spends one DONE cycle pulsing done (and ar_inc if requested).
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_seq_if.slave -- request inputs, RAM strobes, rdata and status
// All outputs are registered; strobes are computed from the next state so
// they line up with the state they describe.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int WAIT = WAIT_DEF
) (
  input logic      clk,
  input logic      rst,
  mem_seq_if.slave bus
);

  if ((WAIT < 0) || (WAIT > MAX_WAIT)) begin : g_wait_range
    $error("mem_seq: WAIT must be in 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);

  state_e        state_r;
  state_e        next_state_s;
  op_e           op_r;
  op_e           next_op_s;
  logic          inc_r;
  logic          start_s;
  logic          cnt_en_s;
  logic          cnt_zero_s;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic [DW-1:0] rdata_r;
  logic          mem_oe_r;
  logic          mem_we_r;
  logic          busy_r;
  logic          done_r;
  logic          ar_inc_r;
  logic          err_r;

  mem_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_s),
    .en       (cnt_en_s),
    .load_val (WAIT_LD),
    .zero     (cnt_zero_s)
  );

  // Next-state, request acceptance and counter enable decode.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    cnt_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rd_req || bus.wr_req) begin
          start_s      = 1'b1;
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_zero_s) begin
          next_state_s = DONE;
        end else begin
          cnt_en_s     = 1'b1;
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operation for the upcoming cycle; read wins when both requests are up.
  always_comb begin
    next_op_s = op_r;
    if (start_s) begin
      next_op_s = bus.rd_req ? OP_RD : OP_WR;
    end else begin
      next_op_s = op_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latches: address, write data, op and increment flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      op_r        <= OP_RD;
      inc_r       <= 1'b0;
    end else if (start_s) begin
      mem_addr_r  <= bus.addr_in;
      mem_wdata_r <= bus.wdata;
      op_r        <= next_op_s;
      inc_r       <= bus.inc;
    end
  end

  // Data register: capture RAM data on the last ACCESS cycle of a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= {DW{1'b0}};
    end else if ((state_r == ACCESS) && cnt_zero_s && (op_r == OP_RD)) begin
      rdata_r <= bus.mem_rdata;
    end
  end

  // Registered strobes and status, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_oe_r <= 1'b0;
      mem_we_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ar_inc_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      mem_oe_r <= (next_state_s == ACCESS) && (next_op_s == OP_RD);
      mem_we_r <= (next_state_s == ACCESS) && (next_op_s == OP_WR);
      busy_r   <= (next_state_s != IDLE);
      done_r   <= (next_state_s == DONE);
      ar_inc_r <= (next_state_s == DONE) && inc_r;
      err_r    <= start_s && bus.rd_req && bus.wr_req;
    end
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_oe    = mem_oe_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.ar_inc    = ar_inc_r;
  assign bus.err       = err_r;

endmodule
